// File: rtl/candidate_generator.sv
// Odometer-order candidate string generator feeding the initial-hash pipeline.
// Emits one 8-char, 7-bit-per-char candidate per enabled cycle over a fixed charset.
module candidate_generator #(
  parameter int unsigned CHARSET_SIZE = 37
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        en,
  input  logic [55:0] prefix,
  input  logic [3:0]  free_cnt,
  output logic [55:0] chars,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [47:0] count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(CHARSET_SIZE - 1);

  state_t      r_state, w_state_nxt;
  logic [55:0] r_prefix, w_prefix_nxt;
  logic [3:0]  r_free, w_free_nxt;
  logic [5:0]  r_digit [8];
  logic [5:0]  w_digit_nxt [8];
  logic [5:0]  w_digit_inc [8];
  logic [55:0] r_chars, w_chars_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_done, w_done_nxt;
  logic [47:0] r_count, w_count_nxt;

  logic [7:0]  w_free_mask;
  logic [55:0] w_cand;
  logic        w_last;

  function automatic logic [6:0] idx2char(input logic [5:0] idx);
    if (idx < 6'd26)      return 7'h61 + 7'(idx);
    else if (idx < 6'd36) return 7'h30 + 7'(idx - 6'd26);
    else                  return 7'h5F;
  endfunction

  // Position k varies when k >= 8-F; r_free never exceeds 8, so the sum fits in 4 bits.
  always_comb begin
    w_free_mask = '0;
    w_cand      = '0;
    w_last      = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      w_free_mask[i] = (4'(i) + r_free) >= 4'd8;
      w_cand[7*i +: 7] = w_free_mask[i] ? idx2char(r_digit[i]) : r_prefix[7*i +: 7];
      if (w_free_mask[i] && (r_digit[i] != LAST_IDX))
        w_last = 1'b0;
    end
  end

  // Ripple carry from position 7 (least significant) toward position 0.
  always_comb begin
    logic       carry;
    logic [2:0] k;
    carry = 1'b1;
    k     = 3'd0;
    for (int unsigned i = 0; i < 8; i++) w_digit_inc[i] = r_digit[i];
    for (int unsigned i = 0; i < 8; i++) begin
      k = 3'(7 - i);
      if (w_free_mask[k] && carry) begin
        if (r_digit[k] == LAST_IDX) begin
          w_digit_inc[k] = '0;
        end else begin
          w_digit_inc[k] = r_digit[k] + 6'd1;
          carry          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prefix_nxt = r_prefix;
    w_free_nxt   = r_free;
    w_digit_nxt  = r_digit;
    w_chars_nxt  = r_chars;
    w_valid_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_count_nxt  = r_count;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_prefix_nxt = prefix;
          w_free_nxt   = (free_cnt > 4'd8) ? 4'd8 : free_cnt;
          w_digit_nxt  = '{default: '0};
          w_count_nxt  = '0;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (en) begin
          w_chars_nxt = w_cand;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count + 48'd1;
          if (w_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_digit_nxt = w_digit_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prefix <= '0;
      r_free   <= '0;
      r_digit  <= '{default: '0};
      r_chars  <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prefix <= w_prefix_nxt;
      r_free   <= w_free_nxt;
      r_digit  <= w_digit_nxt;
      r_chars  <= w_chars_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign chars = r_chars;
  assign valid = r_valid;
  assign done  = r_done;
  assign count = r_count;
  assign busy  = (r_state == RUN);

endmodule

// File: tb/tb_candidate_generator.sv
// Scoreboard bench for candidate_generator: stimulus pushes expected candidates,
// a negedge monitor pops and compares whenever valid is high.
module tb_candidate_generator;

  logic        clk = 1'b0;
  logic        rst, start, stop, en;
  logic [55:0] prefix;
  logic [3:0]  free_cnt;
  logic [55:0] chars;
  logic        valid, busy, done;
  logic [47:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [55:0] chars;
    logic        done;
    logic [47:0] count;
  } exp_t;

  exp_t sb[$];

  localparam logic [55:0] PFX_A = {8{7'h61}};
  localparam logic [55:0] PFX_P = {7'h48, 7'h47, 7'h46, 7'h45, 7'h44, 7'h43, 7'h42, 7'h41};

  candidate_generator #(.CHARSET_SIZE(37)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .prefix(prefix), .free_cnt(free_cnt),
    .chars(chars), .valid(valid), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Base-37 digits of idx, position 7 least significant.
  function automatic logic [55:0] model(input logic [55:0] pfx, input int f, input longint idx);
    string       cs;
    logic [55:0] r;
    longint      rem;
    cs  = "abcdefghijklmnopqrstuvwxyz0123456789_";
    r   = pfx;
    rem = idx;
    for (int k = 7; k >= 8 - f; k--) begin
      r[7*k +: 7] = 7'(cs[int'(rem % 37)]);
      rem = rem / 37;
    end
    return r;
  endfunction

  function automatic longint total_of(input int f);
    longint t = 1;
    for (int i = 0; i < f; i++) t = t * 37;
    return t;
  endfunction

  task automatic push_exp(input logic [55:0] pfx, input int f, input int n);
    exp_t   e;
    longint tot = total_of(f);
    for (int i = 0; i < n; i++) begin
      e.chars = model(pfx, f, longint'(i));
      e.done  = (longint'(i) == tot - 1);
      e.count = 48'(i + 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [55:0] pfx, input logic [3:0] fc);
    prefix   = pfx;
    free_cnt = fc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_valids(input int n, input int budget, output int cyc, output logic [55:0] last);
    int k = 0;
    cyc  = 0;
    last = '0;
    while (k < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) begin
        k++;
        last = chars;
      end
    end
    if (k < n) chk("wait_valids_timeout", 64'(k), 64'(n));
  endtask

  task automatic post_idle(input string name, input logic [47:0] exp_count);
    @(negedge clk);
    chk({name, "_valid"}, 64'(valid), 64'd0);
    chk({name, "_done"},  64'(done),  64'd0);
    chk({name, "_busy"},  64'(busy),  64'd0);
    chk({name, "_count"}, 64'(count), 64'(exp_count));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && valid !== 1'b1) chk("done_without_valid", 64'(valid), 64'd1);
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(chars), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("cand_chars", 64'(chars), 64'(e.chars));
        chk("cand_done",  64'(done),  64'(e.done));
        chk("cand_count", 64'(count), 64'(e.count));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc, cyc2;
    logic [55:0] snap;

    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1;
    prefix = '0; free_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_chars", 64'(chars), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single free position, full run
    push_exp(PFX_A, 1, 37);
    do_start(PFX_A, 4'd1);
    chk("f1_busy_after_start", 64'(busy), 64'd1);
    wait_valids(37, 60, cyc, snap);
    chk("f1_cycles", 64'(cyc), 64'd37);
    chk("f1_last_char7", 64'(snap[55:49]), 64'h5F);
    post_idle("f1_end", 48'd37);

    // Carry across two positions
    push_exp(PFX_A, 2, 1369);
    do_start(PFX_A, 4'd2);
    wait_valids(38, 60, cyc, snap);
    chk("f2_cand38_char6", 64'(snap[48:42]), 64'h62);
    chk("f2_cand38_char7", 64'(snap[55:49]), 64'h61);
    wait_valids(1369 - 38, 1400, cyc2, snap);
    chk("f2_cycles", 64'(cyc + cyc2), 64'd1369);
    post_idle("f2_end", 48'd1369);

    // F=0: prefix only, done on the single candidate
    push_exp(PFX_P, 0, 1);
    do_start(PFX_P, 4'd0);
    wait_valids(1, 10, cyc, snap);
    chk("f0_cycles", 64'(cyc), 64'd1);
    chk("f0_chars", 64'(snap), 64'(PFX_P));
    post_idle("f0_end", 48'd1);

    // free_cnt=12 clamps to 8: every position replaced
    push_exp(PFX_P, 8, 3);
    do_start(PFX_P, 4'd12);
    wait_valids(1, 10, cyc, snap);
    chk("clamp_first", 64'(snap), 64'({8{7'h61}}));
    wait_valids(2, 10, cyc, snap);
    stop = 1'b1;
    post_idle("clamp_stop", 48'd3);
    stop = 1'b0;

    // Stop after candidate 10, then restart from digit 0
    push_exp(PFX_A, 1, 10);
    do_start(PFX_A, 4'd1);
    wait_valids(10, 20, cyc, snap);
    stop = 1'b1;
    post_idle("stop10", 48'd10);
    stop = 1'b0;
    push_exp(PFX_A, 1, 37);
    do_start(PFX_A, 4'd1);
    chk("restart_count0", 64'(count), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_valids(37, 60, cyc, snap);
    post_idle("restart_end", 48'd37);

    // Enable gap after candidate 5
    push_exp(PFX_A, 1, 37);
    do_start(PFX_A, 4'd1);
    wait_valids(5, 20, cyc, snap);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_valid_low", 64'(valid), 64'd0);
      chk("gap_count_hold", 64'(count), 64'd5);
    end
    en = 1'b1;
    wait_valids(1, 5, cyc, snap);
    chk("gap_resume_cycles", 64'(cyc), 64'd1);
    chk("gap_resume_char7", 64'(snap[55:49]), 64'h66);
    wait_valids(31, 60, cyc, snap);
    post_idle("gap_end", 48'd37);

    // Start mid-run with new prefix/free_cnt is ignored
    push_exp(PFX_A, 1, 37);
    do_start(PFX_A, 4'd1);
    wait_valids(3, 10, cyc, snap);
    start = 1'b1; prefix = PFX_P; free_cnt = 4'd2;
    wait_valids(1, 5, cyc, snap);
    start = 1'b0;
    wait_valids(33, 60, cyc, snap);
    post_idle("ignstart_end", 48'd37);

    // Reset mid-run
    push_exp(PFX_A, 1, 4);
    do_start(PFX_A, 4'd1);
    wait_valids(4, 10, cyc, snap);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_chars", 64'(chars), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_busy",  64'(busy),  64'd0);
    chk("midrst_done",  64'(done),  64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_stays_idle", 64'(busy), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
